stumps_bist_ctrl: RTL and testbench

- STUMPS logic-BIST sequencer for the scan-instrumented adder_net (scan chains ir/ac/pc).
- Drives NbarT and the chain scan inputs from an internal PRPG (LFSR).
- Alternates shift and capture for a fixed pattern count and compacts chain scan outputs into a MISR.
- Compares the final signature with a golden value; sits between the top-level test controller and the datapath's scan ports.

---
 rtl/stumps_bist_pkg.sv | 10 +
 rtl/stumps_misr.sv | 20 ++
 rtl/stumps_bist_ctrl.sv | 97 +++++++++
 tb/tb_stumps_bist_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stumps_bist_pkg.sv
// stumps_bist_pkg: state encoding, LFSR constants and the LFSR step shared by PRPG and MISR
package stumps_bist_pkg;
   typedef enum logic [2:0] {IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE} state_t;
   // x^16+x^14+x^13+x^11+1 -> feedback from bits 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/stumps_misr.sv
// stumps_misr: multiple-input signature register with clear, enable and parallel input
// Ports: clk, rst (async, active high), clr (sync clear, wins over en),
//        en (compact this cycle), din (parallel response input), sig (register contents)
module stumps_misr
   import stumps_bist_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] sig
);
   always_ff @(posedge clk or posedge rst)
      if (rst) sig <= '0;
      else if (clr) sig <= '0;
      else if (en) sig <= lfsr_step(sig) ^ din;
endmodule

// File: rtl/stumps_bist_ctrl.sv
// stumps_bist_ctrl: STUMPS logic-BIST sequencer (PRPG-driven shift/capture, MISR compaction, golden compare)
// Ports: clk, rst (async, active high), start (level, honoured in IDLE/DONE),
//        abort (only when BIST_ABORT_EN is defined), NbarT (1 = shift, 0 = capture/normal),
//        chain_si/chain_so (scan chain inputs/outputs, bit 0 = ir, 1 = ac, 2 = pc),
//        busy (INIT..COMPARE), done (DONE), pass (valid with done), signature (MISR contents)
// Optional feature macro: BIST_ABORT_EN
module stumps_bist_ctrl
   import stumps_bist_pkg::*;
#(
   parameter int                NUM_CHAINS   = 3,
   parameter int                CHAIN_LEN    = 32,
   parameter int                NUM_PATTERNS = 32,
   parameter int                LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] SEED         = DEFAULT_SEED,
   parameter logic [LFSR_W-1:0] GOLDEN_SIG   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
`ifdef BIST_ABORT_EN
   input  logic                  abort,
`endif
   output logic                  NbarT,
   output logic [NUM_CHAINS-1:0] chain_si,
   input  logic [NUM_CHAINS-1:0] chain_so,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [LFSR_W-1:0]     signature
);
   localparam int SW = $clog2(CHAIN_LEN + 1);
   localparam int PW = $clog2(NUM_PATTERNS + 1);
   state_t state, state_nxt;
   logic [LFSR_W-1:0] prpg;
   logic [SW-1:0] shift_cnt;
   logic [PW-1:0] pat_cnt;
   logic last_shift, kill, misr_en;
   assign busy = state inside {INIT, SHIFT, CAPTURE, UNLOAD, COMPARE};
   assign done = state == DONE;
   assign NbarT = state inside {SHIFT, UNLOAD};
   assign chain_si = state == SHIFT ? prpg[NUM_CHAINS-1:0] : '0;
   assign last_shift = shift_cnt == SW'(CHAIN_LEN - 1);
`ifdef BIST_ABORT_EN
   assign kill = abort & busy;
`else
   assign kill = 1'b0;
`endif
   // the first load shifts in stimulus only; responses exist from pattern 1 onward
   assign misr_en = (state == SHIFT && pat_cnt != '0) || state == UNLOAD;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? INIT : IDLE;
         INIT:    state_nxt = SHIFT;
         SHIFT:   state_nxt = last_shift ? CAPTURE : SHIFT;
         CAPTURE: state_nxt = pat_cnt == PW'(NUM_PATTERNS - 1) ? UNLOAD : SHIFT;
         UNLOAD:  state_nxt = last_shift ? COMPARE : UNLOAD;
         COMPARE: state_nxt = DONE;
         DONE:    state_nxt = start ? INIT : DONE;
         default: state_nxt = IDLE;
      endcase
      if (kill) state_nxt = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         prpg <= SEED;
         shift_cnt <= '0;
         pat_cnt <= '0;
         pass <= 1'b0;
      end else if (kill) begin
         shift_cnt <= '0;
         pat_cnt <= '0;
         pass <= 1'b0;
      end else begin
         if (state == INIT) begin
            prpg <= SEED;
            shift_cnt <= '0;
            pat_cnt <= '0;
            pass <= 1'b0;
         end
         if (state == SHIFT) prpg <= lfsr_step(prpg);
         if (state inside {SHIFT, UNLOAD}) shift_cnt <= last_shift ? '0 : shift_cnt + 1'b1;
         if (state == CAPTURE) pat_cnt <= pat_cnt + 1'b1;
         if (state == COMPARE) pass <= signature == GOLDEN_SIG;
      end
   stumps_misr #(.W(LFSR_W)) u_misr (
      .clk(clk),
      .rst(rst),
      .clr(state == INIT || kill),
      .en(misr_en),
      .din(LFSR_W'(chain_so)),
      .sig(signature)
   );
endmodule

// File: tb/tb_stumps_bist_ctrl.sv
// tb_stumps_bist_ctrl: randomized scoreboard bench for the STUMPS BIST sequencer
module tb_stumps_bist_ctrl;
   localparam int CL = 32;
   localparam int NP = 32;
   localparam int UNL = 1 + NP * (CL + 1);
   localparam int RUN = UNL + CL + 1;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [15:0] GOLD = 16'h0000;
   logic clk = 0, rst = 1, start = 0;
`ifdef BIST_ABORT_EN
   logic abort = 0;
`endif
   logic NbarT, busy, done, pass;
   logic [2:0] chain_si, chain_so;
   logic [15:0] signature;
   int tcyc = -1;
   int passed = 0, total = 0;
   logic [15:0] prpg_seq [NP*CL];
   logic [31:0] ch [3] = '{default: 32'd0};
   logic [31:0] junk [3] = '{default: 32'd0};
   logic [2:0] steer_so [CL];
   bit f_en = 0, steer = 0;
   int f_t = 0, f_k = 0, f_c = 0;
   logic [15:0] exp_sig = 0;
   logic [16:0] sbq [$];
   logic done_q = 0;

   stumps_bist_ctrl dut (
      .clk(clk),
      .rst(rst),
      .start(start),
`ifdef BIST_ABORT_EN
      .abort(abort),
`endif
      .NbarT(NbarT),
      .chain_si(chain_si),
      .chain_so(chain_so),
      .busy(busy),
      .done(done),
      .pass(pass),
      .signature(signature)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d of run)", name, act, req, tcyc);
   endtask

   // expected schedule derived from the run timeline: INIT, NP x (CL shifts + capture), CL unloads, compare
   function automatic bit in_shift(input int t);
      return t >= 1 && t < UNL && (t - 1) % (CL + 1) != CL;
   endfunction
   function automatic bit exp_nbart(input int t);
      return in_shift(t) || (t >= UNL && t < UNL + CL);
   endfunction
   function automatic logic [2:0] exp_si(input int t);
      logic [15:0] v;
      if (!in_shift(t)) return 3'b000;
      v = prpg_seq[((t - 1) / (CL + 1)) * CL + (t - 1) % (CL + 1)];
      return v[2:0];
   endfunction

   // reference: chain output at shift k is the PRPG bit loaded CL shifts earlier
   task automatic model(output logic [15:0] sig);
      logic [15:0] m, nx;
      logic [2:0] so;
      m = 16'h0000;
      for (int k = CL; k < NP * CL; k++) begin
         nx = prpg_seq[k - CL];
         so = nx[2:0];
         if (f_en && k == f_k) so[f_c] = ~so[f_c];
         m = step(m) ^ {13'd0, so};
      end
      for (int u = 0; u < CL; u++) begin
         nx = prpg_seq[NP * CL - CL + u];
         so = nx[2:0];
         if (steer && u >= CL / 2) begin
            nx = step(m);
            so = nx[2:0];
         end
         steer_so[u] = so;
         m = step(m) ^ {13'd0, so};
      end
      sig = m;
   endtask

   task automatic setup(input bit fe, input int fp, input int fs, input int fc, input bit st);
      f_en = fe;
      f_c = fc;
      f_k = fp * CL + fs;
      f_t = 1 + fp * (CL + 1) + fs;
      steer = st;
      for (int i = 0; i < 3; i++) junk[i] = $urandom;
      model(exp_sig);
   endtask

   // scan chains as CL-bit shift registers; junk stands in for unknown power-up contents
   always @(posedge clk)
      if (NbarT) for (int i = 0; i < 3; i++) ch[i] <= {ch[i][30:0], chain_si[i]};

   always_comb begin
      for (int i = 0; i < 3; i++) chain_so[i] = ch[i][31] ^ ((tcyc >= 1 && tcyc <= CL) ? junk[i][tcyc-1] : 1'b0);
      if (f_en && tcyc == f_t) chain_so[f_c] = ~chain_so[f_c];
      if (steer && tcyc >= UNL + CL / 2 && tcyc < UNL + CL) chain_so = steer_so[tcyc-UNL];
   end

   // run timeline tracker and scoreboard producer
   always @(posedge clk or posedge rst)
      if (rst) begin
         tcyc <= -1;
         sbq.delete();
      end
`ifdef BIST_ABORT_EN
      else if (abort && tcyc >= 0 && tcyc < RUN) begin
         tcyc <= -1;
         sbq.delete();
      end
`endif
      else if (start && (tcyc < 0 || tcyc >= RUN)) begin
         tcyc <= 0;
         sbq.push_back({exp_sig == GOLD, exp_sig});
      end
      else if (tcyc >= 0) tcyc <= tcyc + 1;

   // monitor: per-cycle waveform checks plus scoreboard consumer on done
   always @(negedge clk) begin
      logic [16:0] e;
      if (!rst) begin
         check("NbarT", NbarT, exp_nbart(tcyc));
         check("busy", busy, tcyc >= 0 && tcyc < RUN);
         check("done", done, tcyc >= RUN);
         check("chain_si", chain_si, exp_si(tcyc));
         if (tcyc < 0) begin
            check("idle signature", signature, 0);
            check("idle pass", pass, 0);
         end
         if (tcyc >= 1 && tcyc <= CL + 1) check("first-load signature", signature, 0);
         if (tcyc >= 1 && tcyc < RUN) check("pass during run", pass, 0);
         if (done && !done_q) begin
            if (sbq.size() == 0) check("scoreboard underflow", sbq.size(), 1);
            else begin
               e = sbq.pop_front();
               check("signature", signature, e[15:0]);
               check("pass", pass, e[16]);
            end
         end
      end
      done_q <= done;
   end

   task automatic launch();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < RUN + 50 && !done; i++) @(negedge clk);
      check("done reached", done, 1);
      @(negedge clk);
   endtask

   task automatic wait_t(input int t);
      for (int i = 0; i < RUN + 50 && tcyc != t; i++) @(negedge clk);
      check("run position reached", tcyc, t);
   endtask

   task automatic check_cleared();
      check("cleared NbarT", NbarT, 0);
      check("cleared chain_si", chain_si, 0);
      check("cleared busy", busy, 0);
      check("cleared done", done, 0);
      check("cleared pass", pass, 0);
      check("cleared signature", signature, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1);
   end

   initial begin
      int t;
      prpg_seq[0] = SEED;
      for (int k = 1; k < NP * CL; k++) prpg_seq[k] = step(prpg_seq[k-1]);
      setup(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #2 rst = 0;
      repeat (20) @(negedge clk);
      launch();
      wait_done();
      setup(1, 5, 10, 1, 0);
      launch();
      wait_done();
      // steered unload drives the MISR to the golden value; start stays high into DONE
      setup(1, $urandom_range(1, NP - 1), $urandom_range(0, CL - 1), $urandom_range(0, 2), 1);
      @(negedge clk) start = 1;
      wait_done();
      start = 0;
      wait_done();
      repeat (2) begin
         setup($urandom_range(0, 1), $urandom_range(1, NP - 1), $urandom_range(0, CL - 1),
               $urandom_range(0, 2), $urandom_range(0, 1));
         repeat ($urandom_range(0, 5)) @(negedge clk);
         launch();
         wait_done();
      end
      setup(0, 0, 0, 0, 0);
      launch();
      t = 1 + 17 * (CL + 1) + $urandom_range(0, CL - 1);
      wait_t(t);
      #2 rst = 1;
      #1 check_cleared();
      repeat (2) @(negedge clk);
      #2 rst = 0;
      repeat (5) @(negedge clk);
`ifdef BIST_ABORT_EN
      launch();
      wait_t(t);
      abort = 1;
      @(posedge clk);
      #1 check_cleared();
      @(negedge clk) abort = 0;
      repeat (5) @(negedge clk);
`endif
      launch();
      wait_done();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
